// File: rtl/latch_array_ctrl.sv
// Write sequencer for the 8 x 32-bit latch array (SETUP / PULSE / HOLD) and
// arbiter for its single read port, shared by playback (priority) and host reads.
module latch_array_ctrl #(
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 1,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [2:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic        busy,
    input  logic        host_rd_req,
    input  logic [2:0]  host_rd_addr,
    output logic        host_rd_valid,
    output logic [31:0] host_rd_data,
    input  logic        pb_rd_en,
    input  logic [2:0]  pb_rd_addr,
    output logic [31:0] pb_rd_data,
    output logic        la_write,
    output logic [2:0]  la_write_address,
    output logic [31:0] la_data_in,
    output logic [2:0]  la_read_address,
    input  logic [31:0] la_data_out
);

    localparam int CW = 8;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          hazard;
    logic          host_gnt;

    assign wr_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Each phase reloads cnt on entry and leaves when it reaches 1,
    // so a phase lasts exactly its parameter's number of cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            la_write         <= 1'b0;
            la_write_address <= '0;
            la_data_in       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_valid) begin
                        la_write_address <= wr_addr;
                        la_data_in       <= wr_data;
                        cnt              <= CW'(SETUP_CYCLES);
                        state            <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == CW'(1)) begin
                        state    <= PULSE;
                        cnt      <= CW'(PULSE_CYCLES);
                        la_write <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                PULSE: begin
                    if (cnt == CW'(1)) begin
                        state    <= HOLD;
                        cnt      <= CW'(HOLD_CYCLES);
                        la_write <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt == CW'(1)) state <= IDLE;
                    else               cnt   <= cnt - CW'(1);
                end
                default: begin
                    state    <= IDLE;
                    la_write <= 1'b0;
                end
            endcase
        end
    end

    // A host read of the word being written waits for IDLE so it sees the new data.
    assign hazard          = (state != IDLE) && (host_rd_addr == la_write_address);
    assign host_gnt        = host_rd_req && !pb_rd_en && !host_rd_valid && !hazard;
    assign la_read_address = host_gnt ? host_rd_addr : pb_rd_addr;
    assign pb_rd_data      = la_data_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_rd_valid <= 1'b0;
            host_rd_data  <= '0;
        end else begin
            host_rd_valid <= host_gnt;
            if (host_gnt) host_rd_data <= la_data_out;
        end
    end

endmodule

// File: tb/tb_latch_array_ctrl.sv
// Directed bench for latch_array_ctrl with a behavioural latch-array model.
module tb_latch_array_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [2:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        busy;
    logic        host_rd_req = 1'b0;
    logic [2:0]  host_rd_addr = '0;
    logic        host_rd_valid;
    logic [31:0] host_rd_data;
    logic        pb_rd_en = 1'b0;
    logic [2:0]  pb_rd_addr = '0;
    logic [31:0] pb_rd_data;
    logic        la_write;
    logic [2:0]  la_write_address;
    logic [31:0] la_data_in;
    logic [2:0]  la_read_address;
    logic [31:0] la_data_out;

    // second instance with stretched timing
    logic        wr_valid5 = 1'b0;
    logic        wr_ready5, busy5, host_rd_valid5, la_write5;
    logic [31:0] host_rd_data5, pb_rd_data5, la_data_in5;
    logic [2:0]  la_write_address5, la_read_address5;

    logic [31:0] mem [8] = '{default: 32'h0};
    logic        lw_q = 1'b0;
    int          pulses = 0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    latch_array_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy),
        .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr),
        .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data),
        .pb_rd_en(pb_rd_en), .pb_rd_addr(pb_rd_addr), .pb_rd_data(pb_rd_data),
        .la_write(la_write), .la_write_address(la_write_address), .la_data_in(la_data_in),
        .la_read_address(la_read_address), .la_data_out(la_data_out)
    );

    latch_array_ctrl #(.SETUP_CYCLES(3), .PULSE_CYCLES(2), .HOLD_CYCLES(2)) u5 (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid5), .wr_ready(wr_ready5), .wr_addr(3'd1), .wr_data(32'h1234_5678),
        .busy(busy5),
        .host_rd_req(1'b0), .host_rd_addr(3'd0),
        .host_rd_valid(host_rd_valid5), .host_rd_data(host_rd_data5),
        .pb_rd_en(1'b0), .pb_rd_addr(3'd0), .pb_rd_data(pb_rd_data5),
        .la_write(la_write5), .la_write_address(la_write_address5), .la_data_in(la_data_in5),
        .la_read_address(la_read_address5), .la_data_out(32'h0)
    );

    // latch array model: word captured while the write enable is high
    assign la_data_out = mem[la_read_address];
    always @(posedge clk) begin
        if (la_write) mem[la_write_address] <= la_data_in;
        if (la_write && !lw_q) pulses++;
        lw_q <= la_write;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // returns data and the number of edges until host_rd_valid
    task automatic host_read(input logic [2:0] a, output logic [31:0] d, output int n);
        host_rd_req  = 1'b1;
        host_rd_addr = a;
        n = 0;
        do begin
            tick();
            n++;
        end while (!host_rd_valid && n < 20);
        chk("rd_done", {31'b0, host_rd_valid}, 32'd1);
        d = host_rd_data;
        host_rd_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int          n;
        int          acc, prev_acc, base;
        logic [7:0]  pat, rdy;

        #12;
        chk("rst_la_write", {31'b0, la_write}, 32'd0);
        chk("rst_wr_ready", {31'b0, wr_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_rd_valid", {31'b0, host_rd_valid}, 32'd0);
        chk("rst_rd_data", host_rd_data, 32'd0);
        chk("rst_wr_addr", {29'b0, la_write_address}, 32'd0);
        chk("rst_data_in", la_data_in, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: single write, la_write 0,0,1,0 then ready
        wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 32'hDEAD_BEEF;
        tick();
        wr_valid = 1'b0;
        chk("t1_addr", {29'b0, la_write_address}, 32'd5);
        chk("t1_data", la_data_in, 32'hDEAD_BEEF);
        pat = '0; rdy = '0;
        for (int k = 0; k < 5; k++) begin
            pat[k] = la_write;
            rdy[k] = wr_ready;
            if (k < 4) tick();
        end
        chk("t1_we_pattern", {24'b0, pat}, 32'h04);
        chk("t1_ready_pattern", {24'b0, rdy}, 32'h10);
        host_read(3'd5, d, n);
        chk("t1_rd_data", d, 32'hDEAD_BEEF);
        chk("t1_rd_lat", n, 32'd1);
        tick();

        // 2: back-to-back writes with wr_valid held
        base = pulses;
        prev_acc = 0;
        wr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_addr = 3'(i);
            wr_data = 32'h1111_1111 * i;
            n = 0;
            while (!wr_ready && n < 20) begin
                tick();
                n++;
            end
            acc = cyc;
            tick();
            if (i > 0) chk("t2_period", acc - prev_acc, 32'd5);
            prev_acc = acc;
        end
        wr_valid = 1'b0;
        wait_idle();
        tick();
        chk("t2_pulses", pulses - base, 32'd8);
        for (int i = 0; i < 8; i++) begin
            host_read(3'(i), d, n);
            chk("t2_readback", d, 32'h1111_1111 * i);
            tick();
        end

        // 3: playback blocks host reads
        pb_rd_en = 1'b1; pb_rd_addr = 3'd7;
        host_rd_req = 1'b1; host_rd_addr = 3'd2;
        #1;
        chk("t3_pb_data", pb_rd_data, 32'h7777_7777);
        chk("t3_rd_addr", {29'b0, la_read_address}, 32'd7);
        rdy = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            rdy[k] = host_rd_valid;
        end
        chk("t3_no_valid", {24'b0, rdy}, 32'h0);
        pb_rd_en = 1'b0;
        host_read(3'd2, d, n);
        chk("t3_lat", n, 32'd1);
        chk("t3_data", d, 32'h2222_2222);
        tick();

        // 4: hazard on address being written; other addresses read through
        wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 32'hA5A5_A5A5;
        tick();
        wr_valid = 1'b0;
        host_read(3'd4, d, n);
        chk("t4_nohaz_lat", n, 32'd1);
        chk("t4_nohaz_data", d, 32'h4444_4444);
        chk("t4_still_busy", {31'b0, busy}, 32'd1);
        host_read(3'd3, d, n);
        chk("t4_haz_lat", n, 32'd4);
        chk("t4_haz_data", d, 32'hA5A5_A5A5);
        tick();

        // 5: SETUP=3, PULSE=2, HOLD=2
        wr_valid5 = 1'b1;
        tick();
        pat = '0; rdy = '0;
        for (int k = 0; k < 8; k++) begin
            pat[k] = la_write5;
            rdy[k] = wr_ready5;
            tick();
        end
        chk("t5_we_pattern", {24'b0, pat}, 32'h18);
        chk("t5_ready_pattern", {24'b0, rdy}, 32'h80);
        chk("t5_reaccept", {31'b0, busy5}, 32'd1);
        wr_valid5 = 1'b0;
        for (int k = 0; k < 10; k++) tick();

        // 6: reset during PULSE, with a host read granted the same cycle
        wr_valid = 1'b1; wr_addr = 3'd6; wr_data = 32'hCAFE_F00D;
        tick();
        wr_valid = 1'b0;
        tick(); tick();
        chk("t6_in_pulse", {31'b0, la_write}, 32'd1);
        host_rd_req = 1'b1; host_rd_addr = 3'd1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_we_drop", {31'b0, la_write}, 32'd0);
        chk("t6_busy", {31'b0, busy}, 32'd0);
        chk("t6_addr", {29'b0, la_write_address}, 32'd0);
        chk("t6_data_in", la_data_in, 32'd0);
        tick();
        chk("t6_valid_drop", {31'b0, host_rd_valid}, 32'd0);
        chk("t6_rd_data", host_rd_data, 32'd0);
        host_rd_req = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("t6_ready", {31'b0, wr_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
